rx_sfd_strip: RTL and testbench

RX_SFD_STRIP -- requirements
Module: rx_sfd_strip

---
 rtl/gemac_rx_pkg.sv | 36 +++
 rtl/rx_sfd_strip.sv | 195 +++++++++++++++++++
 tb/tb_rx_sfd_strip.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemac_rx_pkg.sv
// Purpose : shared types and constants for the GMII receive front end.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   rx_state_t     receive FSM state encoding
//   PREAMBLE_BYTE  0x55 preamble octet
//   SFD_BYTE       0xD5 start-of-frame delimiter
//   MIN_FRAME      shortest legal frame in bytes (DA through FCS)
//   len_sat_inc    saturating increment for the frame length counter
package gemac_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_FRAME    = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         MIN_FRAME     = 64;

  // Frame length counter width and its saturation value (2047).
  localparam int               LEN_W   = 11;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  // Preamble counter width and its saturation value (7).
  localparam int               PRE_W   = 3;
  localparam logic [PRE_W-1:0] PRE_SAT = '1;

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
    return (v == LEN_SAT) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/rx_sfd_strip.sv
// Purpose : strips preamble/SFD from a GMII receive stream and frames the payload.
// Latency : 1 cycle from gmii_rxd to data; eof one cycle after the last data_valid.
// Backpressure: none -- GMII cannot be stalled, every accepted byte is emitted.
//
// Ports:
//   clk, reset_n                      single clock, async active-low reset
//   gmii_rx_dv, gmii_rx_er, gmii_rxd  GMII receive inputs
//   data, data_valid                  frame bytes (DA..FCS), preamble/SFD removed
//   go                                pulse with the first DA byte
//   eof                               pulse the cycle after the last data byte
//   frame_err, too_long, runt         frame status, valid with eof
//   frame_len                         byte count (saturates at 2047), valid with eof
//
// Build option: define RX_LEN_CHECK_EN to enable runt detection and truncation of
// frames longer than MAX_LEN. Without it too_long/runt stay 0 and frames are never cut.
module rx_sfd_strip
  import gemac_rx_pkg::*;
#(
  parameter int MIN_PREAMBLE = 1,
  parameter int MAX_LEN      = 1518
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic [7:0]       gmii_rxd,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             go,
  output logic             eof,
  output logic             frame_err,
  output logic             too_long,
  output logic             runt,
  output logic [LEN_W-1:0] frame_len
);

  // Catch nonsensical parameterisations at elaboration rather than in the lab.
  if (MIN_PREAMBLE < 1 || MIN_PREAMBLE > 7 || MAX_LEN < MIN_FRAME || MAX_LEN > 2046)
  begin : g_bad_params
    $error("rx_sfd_strip: MIN_PREAMBLE must be 1..7 and MAX_LEN 64..2046");
  end

  localparam logic [PRE_W-1:0] MIN_PRE_L = PRE_W'(MIN_PREAMBLE);
`ifdef RX_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] MAX_LEN_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_FRAME_L = LEN_W'(MIN_FRAME);
`endif

  // Reset: assertion is immediate, release is retimed to clk so every flop
  // leaves reset on the same edge.
  logic rst_meta_q;
  logic rst_sync_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_n <= rst_meta_q;
    end
  end

  rx_state_t        state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  // Previous-cycle rx_dv. Resets to 1 so that a burst already running when
  // reset releases looks like it started mid-frame and is dropped.
  logic             rx_dv_q;

  logic [7:0]       data_d;
  logic             data_valid_d;
  logic             go_d;
  logic             eof_d;
  logic             frame_err_d;
  logic             too_long_d;
  logic             runt_d;
  logic [LEN_W-1:0] frame_len_d;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      rx_dv_q    <= 1'b1;
      data       <= '0;
      data_valid <= 1'b0;
      go         <= 1'b0;
      eof        <= 1'b0;
      frame_err  <= 1'b0;
      too_long   <= 1'b0;
      runt       <= 1'b0;
      frame_len  <= '0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      len_q      <= len_d;
      err_q      <= err_d;
      rx_dv_q    <= gmii_rx_dv;
      data       <= data_d;
      data_valid <= data_valid_d;
      go         <= go_d;
      eof        <= eof_d;
      frame_err  <= frame_err_d;
      too_long   <= too_long_d;
      runt       <= runt_d;
      frame_len  <= frame_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    len_d        = len_q;
    err_d        = err_q;
    data_d       = '0;
    data_valid_d = 1'b0;
    go_d         = 1'b0;
    eof_d        = 1'b0;
    frame_err_d  = 1'b0;
    too_long_d   = 1'b0;
    runt_d       = 1'b0;
    frame_len_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE && !rx_dv_q) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = PRE_W'(1);
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          pre_cnt_d = (pre_cnt_q == PRE_SAT) ? pre_cnt_q : pre_cnt_q + PRE_W'(1);
        end else if (gmii_rxd == SFD_BYTE && pre_cnt_q >= MIN_PRE_L) begin
          // Status of the previous frame is forgotten at every SFD.
          state_d = ST_FRAME;
          len_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_FRAME: begin
        if (!gmii_rx_dv) begin
          state_d     = ST_IDLE;
          eof_d       = 1'b1;
          frame_len_d = len_q;
`ifdef RX_LEN_CHECK_EN
          runt_d      = (len_q < MIN_FRAME_L);
`endif
          frame_err_d = err_q | runt_d;
        end
`ifdef RX_LEN_CHECK_EN
        // MAX_LEN bytes already delivered: this byte is one too many. Close the
        // frame here and swallow the rest of the burst.
        else if (len_q == MAX_LEN_L) begin
          state_d     = ST_DROP;
          eof_d       = 1'b1;
          too_long_d  = 1'b1;
          frame_err_d = 1'b1;
          frame_len_d = len_sat_inc(len_q);
        end
`endif
        else begin
          data_d       = gmii_rxd;
          data_valid_d = 1'b1;
          // Counter saturates well above zero, so zero marks only the DA byte.
          go_d         = (len_q == '0);
          len_d        = len_sat_inc(len_q);
          err_d        = err_q | gmii_rx_er;
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_sfd_strip.sv
module tb_rx_sfd_strip;

  localparam int MIN_PRE = 2;
  localparam int MAXL    = 1518;
  localparam int N       = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic [7:0]  data;
  logic        data_valid, go, eof, frame_err, too_long, runt;
  logic [10:0] frame_len;

  always #5 clk = ~clk;

  rx_sfd_strip #(.MIN_PREAMBLE(MIN_PRE), .MAX_LEN(MAXL)) dut (
    .clk(clk), .reset_n(reset_n),
    .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
    .data(data), .data_valid(data_valid), .go(go), .eof(eof),
    .frame_err(frame_err), .too_long(too_long), .runt(runt), .frame_len(frame_len)
  );

  int tests = 0;
  int fails = 0;

  // Stimulus trace (index = cycle) and expected outputs for the same cycle.
  bit         s_dv[N], s_er[N], s_rst[N];
  logic [7:0] s_rxd[N];
  int         tlen;
  bit         e_vld[N], e_go[N], e_eof[N], e_err[N], e_tl[N], e_runt[N];
  logic [7:0] e_dat[N];
  int         e_len[N];

  // Observations of the DUT over one trace, for the literal checks.
  int         o_vld, o_go, o_eof;
  int         o_go_dat;
  int         q_len[$], q_err[$], q_tl[$], q_runt[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qi(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic push(input bit dv, input bit er, input logic [7:0] d);
    if (tlen < N) begin
      s_dv[tlen] = dv; s_er[tlen] = er; s_rxd[tlen] = d; s_rst[tlen] = 1'b0;
      tlen++;
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_frame(input int npre, input int nbytes, input int er_at,
                            input logic [7:0] sfd, input bit rnd);
    for (int p = 0; p < npre; p++)
      push(1'b1, rnd ? ($urandom_range(0, 7) == 0) : 1'b0, 8'h55);
    push(1'b1, 1'b0, sfd);
    for (int k = 0; k < nbytes; k++)
      push(1'b1, k == er_at, rnd ? 8'($urandom_range(0, 255)) : 8'(k));
  endtask

  // Reference model: split the trace into rx_dv bursts and decide per burst.
  task automatic build_expected();
    int i, s, e, rstart, n, p, l;
    bit acc, trunc, rn;
    for (int k = 0; k < tlen; k++) begin
      e_vld[k] = 0; e_go[k] = 0; e_eof[k] = 0; e_err[k] = 0;
      e_tl[k] = 0; e_runt[k] = 0; e_dat[k] = 8'h00; e_len[k] = 0;
    end
    i = 0;
    while (i < tlen) begin
      if (!s_dv[i]) begin
        i++;
      end else begin
        s = i; e = s;
        while (e < tlen && s_dv[e]) e++;
        rstart = -1;
        for (int k = s; k <= e && k < tlen; k++)
          if (s_rst[k] && rstart < 0) rstart = k;
        n = 0;
        while (s + n < e && s_rxd[s + n] == 8'h55) n++;
        p = s + n;
        if (n > 0 && p < e && s_rxd[p] == 8'hD5 && n >= MIN_PRE) begin
          acc = 0; trunc = 0;
          for (int j = p + 1; j < e; j++) begin
            if (rstart >= 0 && j >= rstart) break;
`ifdef RX_LEN_CHECK_EN
            if (j - p - 1 == MAXL) begin
              e_eof[j] = 1; e_len[j] = MAXL + 1; e_err[j] = 1; e_tl[j] = 1;
              trunc = 1;
              break;
            end
`endif
            e_vld[j] = 1; e_dat[j] = s_rxd[j]; e_go[j] = (j == p + 1);
            acc |= s_er[j];
          end
          l = e - p - 1;
          if (!trunc && rstart < 0 && e < tlen) begin
            rn = 0;
`ifdef RX_LEN_CHECK_EN
            rn = (l < 64);
`endif
            e_eof[e] = 1; e_len[e] = (l > 2047) ? 2047 : l;
            e_runt[e] = rn; e_err[e] = acc | rn;
          end
        end
        i = e;
      end
    end
  endtask

  task automatic outputs_zero(input string name);
    chk(name, int'({data_valid, go, eof, frame_err, too_long, runt}) + int'(data) + int'(frame_len), 0);
  endtask

  task automatic run_trace();
    bit prev_rst;
    build_expected();
    o_vld = 0; o_go = 0; o_eof = 0; o_go_dat = -1;
    q_len.delete(); q_err.delete(); q_tl.delete(); q_runt.delete();
    for (int i = 0; i < tlen; i++) begin
      @(negedge clk);
      prev_rst   = !reset_n;
      reset_n    = !s_rst[i];
      gmii_rx_dv = s_dv[i];
      gmii_rx_er = s_er[i];
      gmii_rxd   = s_rxd[i];
      if (s_rst[i] && !prev_rst) begin
        #1;
        outputs_zero("reset_immediate");
      end
      @(posedge clk);
      #1;
      chk("data_valid", data_valid, e_vld[i]);
      chk("go", go, e_go[i]);
      chk("eof", eof, e_eof[i]);
      if (e_vld[i]) chk("data", data, e_dat[i]);
      if (e_eof[i]) begin
        chk("frame_len", frame_len, e_len[i]);
        chk("frame_err", frame_err, e_err[i]);
        chk("too_long", too_long, e_tl[i]);
        chk("runt", runt, e_runt[i]);
      end
      if (data_valid) o_vld++;
      if (go) begin o_go++; o_go_dat = data; end
      if (eof) begin
        q_len.push_back(frame_len); q_err.push_back(frame_err);
        q_tl.push_back(too_long); q_runt.push_back(runt);
        o_eof++;
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, exp_v, exp_l, exp_t;
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // 7 preamble, SFD, 64 counting bytes
    tlen = 0;
    push_idle(4); push_frame(7, 64, -1, 8'hD5, 0); push_idle(4);
    run_trace();
    chk("t1_vld_count", o_vld, 64);
    chk("t1_go_count", o_go, 1);
    chk("t1_go_data", o_go_dat, 0);
    chk("t1_eof_count", o_eof, 1);
    chk("t1_len", qi(q_len, 0), 64);
    chk("t1_err", qi(q_err, 0), 0);

    // Preamble too short, preamble cut by dv=0, then exactly MIN_PRE preamble
    tlen = 0;
    push_frame(1, 10, -1, 8'hD5, 0); push_idle(2);
    push(1, 0, 8'h55); push(1, 0, 8'h55); push(1, 0, 8'h55); push_idle(2);
    push_frame(2, 64, -1, 8'hD5, 0); push_idle(3);
    run_trace();
    chk("t2_vld_count", o_vld, 64);
    chk("t2_go_count", o_go, 1);
    chk("t2_eof_count", o_eof, 1);

    // rx_er on byte 20
    tlen = 0;
    push_frame(7, 64, 20, 8'hD5, 0); push_idle(3);
    run_trace();
    chk("t3_vld_count", o_vld, 64);
    chk("t3_err", qi(q_err, 0), 1);
    chk("t3_len", qi(q_len, 0), 64);

    // Over-length frame then a 40-byte frame
    tlen = 0;
    push_frame(7, 1519, -1, 8'hD5, 0); push_idle(1);
    push_frame(7, 40, -1, 8'hD5, 0); push_idle(3);
    run_trace();
`ifdef RX_LEN_CHECK_EN
    exp_v = 1518 + 40; exp_t = 1;
`else
    exp_v = 1519 + 40; exp_t = 0;
`endif
    chk("t4_vld_count", o_vld, exp_v);
    chk("t4_len0", qi(q_len, 0), 1519);
    chk("t4_too_long0", qi(q_tl, 0), exp_t);
    chk("t4_runt1", qi(q_runt, 1), exp_t);
    chk("t4_len1", qi(q_len, 1), 40);

    // Reset pulsed at byte 30, held while the burst continues, then a clean frame
    tlen = 0;
    push_idle(3);
    base = tlen;
    push_frame(7, 64, -1, 8'hD5, 0);
    for (int r = 0; r < 3; r++) s_rst[base + 8 + 30 + r] = 1'b1;
    push_idle(6); push_frame(7, 64, -1, 8'hD5, 0); push_idle(4);
    run_trace();
    chk("t5_vld_count", o_vld, 94);
    chk("t5_go_count", o_go, 2);
    chk("t5_eof_count", o_eof, 1);
    chk("t5_len", qi(q_len, 0), 64);

    // Back-to-back frames with a single idle cycle
    tlen = 0;
    push_frame(7, 70, -1, 8'hD5, 0); push_idle(1);
    push_frame(7, 65, -1, 8'hD5, 0); push_idle(3);
    run_trace();
    chk("t6_eof_count", o_eof, 2);
    chk("t6_go_count", o_go, 2);
    chk("t6_len0", qi(q_len, 0), 70);
    chk("t6_len1", qi(q_len, 1), 65);

    // Randomised bursts
    tlen = 0;
    for (int f = 0; f < 12; f++) begin
      int nb;
      nb = $urandom_range(1, 120);
      push_frame($urandom_range(0, 8), nb,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1,
                 ($urandom_range(0, 9) == 0) ? 8'h5D : 8'hD5, 1);
      push_idle($urandom_range(1, 3));
    end
    push_idle(2);
    run_trace();

    // Length counter saturation
    tlen = 0;
    push_frame(7, 2100, -1, 8'hD5, 1); push_idle(3);
    run_trace();
`ifdef RX_LEN_CHECK_EN
    exp_v = 1518; exp_l = 1519;
`else
    exp_v = 2100; exp_l = 2047;
`endif
    chk("t8_vld_count", o_vld, exp_v);
    chk("t8_len", qi(q_len, 0), exp_l);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
